digital_tube_scan: RTL and testbench

Parametrised multiplexed 7-segment scanner, successor to the fixed 8-digit hex driver. It drives DIGITS common-select digits with a per-digit decimal point, per-digit blank mask and leading-zero blanking. Display data is double-buffered: new values take effect only at a frame boundary, with a load/ack handshake. Brightness is set by PWM within each digit slot. It sits between any register or counter producing a packed hex value and the board's segment/select pins.

---
 rtl/digital_tube_scan.sv | 233 +++++++++++++++++++++++
 tb/tb_digital_tube_scan.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digital_tube_scan.sv
// Multiplexed 7-segment scanner with double-buffered display data.
// Digits are scanned one slot at a time. Brightness comes from a PWM window
// inside each slot. New data is staged on load and moves into the shadow
// (displayed) copy only at a frame boundary, or at once while scanning is
// disabled. All pin-facing outputs are registered.
module digital_tube_scan #(
    parameter int DIGITS         = 8,
    parameter int CNT_MAX        = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   disp_data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  lzb,
    input  logic [3:0]            bright,
    input  logic                  load,
    output logic                  load_ack,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame_start
);

    localparam int CW = $clog2(CNT_MAX);
    localparam int IW = $clog2(DIGITS);

    localparam logic [CW-1:0]     CNT_LAST = CW'(CNT_MAX - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [31:0]       PWM_STEP = 32'(CNT_MAX / 16);
    localparam logic [6:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF   = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [DIGITS-1:0] SEL_OFF  = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // Hex digit to active-low segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] code;
        case (v)
            4'h0:    code = 7'h40;
            4'h1:    code = 7'h79;
            4'h2:    code = 7'h24;
            4'h3:    code = 7'h30;
            4'h4:    code = 7'h19;
            4'h5:    code = 7'h12;
            4'h6:    code = 7'h02;
            4'h7:    code = 7'h78;
            4'h8:    code = 7'h00;
            4'h9:    code = 7'h10;
            4'hA:    code = 7'h08;
            4'hB:    code = 7'h03;
            4'hC:    code = 7'h46;
            4'hD:    code = 7'h21;
            4'hE:    code = 7'h06;
            4'hF:    code = 7'h0E;
            default: code = 7'h7F;
        endcase
        return code;
    endfunction

    // Segment pattern at the board's pin polarity.
    function automatic logic [6:0] seg_drive(input logic [3:0] v);
        logic [6:0] low_code;
        low_code = hex_to_seg(v);
        if (SEG_ACTIVE_LOW != 0) begin
            return low_code;
        end else begin
            return ~low_code;
        end
    endfunction

    // Scan position and brightness
    logic [CW-1:0]         cnt_r;
    logic [IW-1:0]         idx_r;
    logic [3:0]            bright_q_r;

    // Double buffer
    logic                  pending_r;
    logic [4*DIGITS-1:0]   stage_data_r;
    logic [DIGITS-1:0]     stage_dp_r;
    logic [DIGITS-1:0]     stage_blank_r;
    logic [4*DIGITS-1:0]   shadow_data_r;
    logic [DIGITS-1:0]     shadow_dp_r;
    logic [DIGITS-1:0]     shadow_blank_r;

    // Registered outputs
    logic                  load_ack_r;
    logic [6:0]            seg_r;
    logic                  dp_r;
    logic [DIGITS-1:0]     sel_r;
    logic                  frame_start_r;

    // Combinational helpers
    logic                  tick_s;
    logic                  boundary_s;
    logic                  xfer_s;
    logic [31:0]           on_time_s;
    logic                  lit_s;
    logic [DIGITS-1:0]     lz_s;
    logic                  zero_run_s;
    logic [3:0]            nib_s;
    logic [DIGITS-1:0]     onehot_s;
    logic [6:0]            seg_next_s;
    logic                  dp_next_s;
    logic [DIGITS-1:0]     sel_next_s;

    assign tick_s     = en && (cnt_r == CNT_LAST);
    assign boundary_s = tick_s && (idx_r == IDX_LAST);
    assign xfer_s     = (boundary_s || !en) && pending_r;
    assign on_time_s  = (32'(bright_q_r) + 32'd1) * PWM_STEP;
    assign lit_s      = en && !shadow_blank_r[idx_r] && (32'(cnt_r) < on_time_s);
    assign nib_s      = shadow_data_r[4*idx_r +: 4];

    // Leading-zero map: lz_s[i] is set when nibbles DIGITS-1..i are all zero.
    always_comb begin
        zero_run_s = 1'b1;
        lz_s       = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run_s = zero_run_s && (shadow_data_r[4*i +: 4] == 4'h0);
            lz_s[i]    = zero_run_s;
        end
    end

    // Next output pattern for the current slot position.
    always_comb begin
        seg_next_s = SEG_OFF;
        dp_next_s  = DP_OFF;
        sel_next_s = SEL_OFF;
        onehot_s   = '0;
        onehot_s[idx_r] = 1'b1;
        if (lit_s) begin
            sel_next_s = (SEL_ACTIVE_LOW != 0) ? ~onehot_s : onehot_s;
            if (lzb && lz_s[idx_r]) begin
                seg_next_s = SEG_OFF;
            end else begin
                seg_next_s = seg_drive(nib_s);
            end
            if (shadow_dp_r[idx_r]) begin
                dp_next_s = ~DP_OFF;
            end else begin
                dp_next_s = DP_OFF;
            end
        end else begin
            seg_next_s = SEG_OFF;
            dp_next_s  = DP_OFF;
            sel_next_s = SEL_OFF;
        end
    end

    // Slot counter and digit index; both hold while scanning is disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
            idx_r <= '0;
        end else if (tick_s) begin
            cnt_r <= '0;
            idx_r <= (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
        end else if (en) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
            idx_r <= idx_r;
        end
    end

    // Brightness is sampled once per slot so a slot never changes width midway.
    always_ff @(posedge clk) begin
        if (rst || tick_s) begin
            bright_q_r <= bright;
        end else begin
            bright_q_r <= bright_q_r;
        end
    end

    // Staging/shadow buffers; shadow always takes the staging copy from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r      <= 1'b0;
            stage_data_r   <= '0;
            stage_dp_r     <= '0;
            stage_blank_r  <= '0;
            shadow_data_r  <= '0;
            shadow_dp_r    <= '0;
            shadow_blank_r <= '0;
            load_ack_r     <= 1'b0;
        end else begin
            load_ack_r <= xfer_s;
            if (xfer_s) begin
                shadow_data_r  <= stage_data_r;
                shadow_dp_r    <= stage_dp_r;
                shadow_blank_r <= stage_blank_r;
            end else begin
                shadow_data_r  <= shadow_data_r;
                shadow_dp_r    <= shadow_dp_r;
                shadow_blank_r <= shadow_blank_r;
            end
            if (load) begin
                stage_data_r  <= disp_data;
                stage_dp_r    <= dp_in;
                stage_blank_r <= blank_in;
            end else begin
                stage_data_r  <= stage_data_r;
                stage_dp_r    <= stage_dp_r;
                stage_blank_r <= stage_blank_r;
            end
            pending_r <= load || (pending_r && !xfer_s);
        end
    end

    // Output registers: one cycle behind the scan position.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r         <= SEG_OFF;
            dp_r          <= DP_OFF;
            sel_r         <= SEL_OFF;
            frame_start_r <= 1'b0;
        end else begin
            seg_r         <= seg_next_s;
            dp_r          <= dp_next_s;
            sel_r         <= sel_next_s;
            frame_start_r <= en && (cnt_r == '0) && (idx_r == '0);
        end
    end

    assign load_ack    = load_ack_r;
    assign seg         = seg_r;
    assign dp          = dp_r;
    assign sel         = sel_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_digital_tube_scan.sv
// Self-checking bench for digital_tube_scan (4 digits, 32-cycle slots).
// A frame-position reference model predicts every output cycle.
module tb_digital_tube_scan;

    localparam int ND    = 4;
    localparam int CM    = 32;
    localparam int FRAME = ND * CM;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] disp_data;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lzb;
    logic [3:0]  bright;
    logic        load;
    logic        load_ack;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  sel;
    logic        frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    digital_tube_scan #(
        .DIGITS(ND), .CNT_MAX(CM), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .disp_data(disp_data), .dp_in(dp_in),
        .blank_in(blank_in), .lzb(lzb), .bright(bright), .load(load),
        .load_ack(load_ack), .seg(seg), .dp(dp), .sel(sel), .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [13:0] obs = {seg, dp, sel, frame_start, load_ack};

    // Reference model: the whole scan is one position 0..FRAME-1 in the frame.
    logic [6:0]  seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          m_pos;
    logic [3:0]  m_bright;
    bit          m_pend;
    logic [15:0] m_sd, m_hd;
    logic [3:0]  m_sdp, m_sbl, m_hdp, m_hbl;
    logic [13:0] exp_v;

    task automatic model_step();
        int c, d;
        bit lit, lzoff, tick, bnd, xfer;
        logic [6:0] e_seg;
        logic e_dp, e_fs, e_ack;
        logic [3:0] e_sel;
        if (rst) begin
            m_pos = 0; m_bright = bright; m_pend = 0;
            m_sd = 0; m_sdp = 0; m_sbl = 0; m_hd = 0; m_hdp = 0; m_hbl = 0;
            exp_v = {7'h7F, 1'b1, 4'h0, 1'b0, 1'b0};
        end else begin
            c = m_pos % CM;
            d = m_pos / CM;
            lit   = en && !m_hbl[d] && (c < (int'(m_bright) + 1) * CM / 16);
            lzoff = lzb && d > 0 && ((m_hd >> (4 * d)) == 16'h0);
            e_sel = lit ? 4'(1 << d) : 4'h0;
            e_seg = (lit && !lzoff) ? seg_lut[m_hd[4*d +: 4]] : 7'h7F;
            e_dp  = (lit && m_hdp[d]) ? 1'b0 : 1'b1;
            e_fs  = en && m_pos == 0;
            tick  = en && c == CM - 1;
            bnd   = en && m_pos == FRAME - 1;
            xfer  = (bnd || !en) && m_pend;
            e_ack = xfer;
            if (xfer) begin
                m_hd = m_sd; m_hdp = m_sdp; m_hbl = m_sbl;
            end
            if (load) begin
                m_sd = disp_data; m_sdp = dp_in; m_sbl = blank_in;
            end
            m_pend = load || (m_pend && !xfer);
            if (tick) m_bright = bright;
            if (en) m_pos = (m_pos + 1) % FRAME;
            exp_v = {e_seg, e_dp, e_sel, e_fs, e_ack};
        end
    endtask

    // One clock: model consumes the same inputs the DUT samples, then settle.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic advance_to(input int p);
        int k;
        k = 0;
        while (m_pos != p && k < 2 * FRAME) begin
            cyc();
            k++;
        end
        n_tests++;
        if (m_pos != p) begin
            n_fail++;
            $display("FAIL align: position %0d, required %0d", m_pos, p);
        end
    endtask

    task automatic test_reset();
        rst = 1; en = 1; load = 0; lzb = 0; bright = 4'hF;
        disp_data = 16'h0; dp_in = 4'h0; blank_in = 4'h0;
        cyc(); cyc();
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++; $display("FAIL reset_model: got %h required %h", obs, exp_v);
        end
        n_tests++;
        if (obs !== {7'h7F, 1'b1, 4'h0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL reset_idle: got %h required %h", obs, {7'h7F, 1'b1, 4'h0, 1'b0, 1'b0});
        end
        rst = 0;
        cyc();
        n_tests++;
        if (sel !== 4'b0001 || frame_start !== 1'b1 || seg !== 7'h40) begin
            n_fail++; $display("FAIL reset_first_digit: got sel=%b fs=%b seg=%h required 0001 1 40", sel, frame_start, seg);
        end
    endtask

    task automatic test_scan();
        int acks, last_fs;
        bit active;
        logic [6:0] want;
        bright = 4'hF; disp_data = 16'h12AF; dp_in = 0; blank_in = 0; lzb = 0;
        load = 1; cyc(); load = 0;
        acks = 0; last_fs = -1; active = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            cyc();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL scan_model cyc %0d: got %h required %h", i, obs, exp_v);
            end
            if (active && sel !== 4'h0) begin
                case (sel)
                    4'b0001: want = 7'h0E;
                    4'b0010: want = 7'h08;
                    4'b0100: want = 7'h24;
                    4'b1000: want = 7'h79;
                    default: want = 7'h7F;
                endcase
                n_tests++;
                if (seg !== want) begin
                    n_fail++; $display("FAIL scan_seg cyc %0d sel=%b: got %h required %h", i, sel, seg, want);
                end
            end
            if (load_ack) begin
                acks++; active = 1;
            end
            if (frame_start) begin
                if (last_fs >= 0) begin
                    n_tests++;
                    if (i - last_fs != FRAME) begin
                        n_fail++; $display("FAIL scan_frame_period: got %0d required %0d", i - last_fs, FRAME);
                    end
                end
                last_fs = i;
            end
        end
        n_tests++;
        if (acks != 1) begin
            n_fail++; $display("FAIL scan_ack_count: got %0d required 1", acks);
        end
    endtask

    task automatic test_pwm();
        int lit;
        bright = 4'd3;
        for (int i = 0; i < FRAME; i++) cyc();
        lit = 0;
        for (int i = 0; i < FRAME; i++) begin
            cyc();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL pwm_model cyc %0d: got %h required %h", i, obs, exp_v);
            end
            if (sel !== 4'h0) lit++;
        end
        n_tests++;
        if (lit != 4 * 8) begin
            n_fail++; $display("FAIL pwm_lit_count: got %0d required %0d", lit, 4 * 8);
        end
        advance_to(CM + 10);
        bright = 4'hF;
        lit = 0;
        for (int i = 0; i < (CM - 10) + CM; i++) begin
            cyc();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL pwm_change_model cyc %0d: got %h required %h", i, obs, exp_v);
            end
            if (sel !== 4'h0) lit++;
        end
        n_tests++;
        if (lit != CM) begin
            n_fail++; $display("FAIL pwm_change_count: got %0d required %0d", lit, CM);
        end
    endtask

    task automatic test_lzb();
        bit active;
        logic [7:0] want;
        bright = 4'hF; lzb = 1; disp_data = 16'h0030; dp_in = 4'b0100; blank_in = 0;
        load = 1; cyc(); load = 0;
        active = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL lzb_model cyc %0d: got %h required %h", i, obs, exp_v);
            end
            if (active && sel !== 4'h0) begin
                case (sel)
                    4'b1000: want = {7'h7F, 1'b1};
                    4'b0100: want = {7'h7F, 1'b0};
                    4'b0010: want = {7'h30, 1'b1};
                    4'b0001: want = {7'h40, 1'b1};
                    default: want = 8'h00;
                endcase
                n_tests++;
                if ({seg, dp} !== want) begin
                    n_fail++; $display("FAIL lzb_digit sel=%b: got %h required %h", sel, {seg, dp}, want);
                end
            end
            if (load_ack) active = 1;
        end
        lzb = 0; dp_in = 0;
    endtask

    task automatic test_back_to_back();
        int acks, ack_at;
        bit active;
        logic [6:0] want;
        advance_to(60);
        disp_data = 16'h3333; load = 1; cyc(); load = 0;
        advance_to(FRAME - 2);
        disp_data = 16'h5A5A; load = 1; cyc(); load = 0;
        acks = 0; ack_at = -1; active = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL b2b_model cyc %0d: got %h required %h", i, obs, exp_v);
            end
            if (active && (sel == 4'b0001 || sel == 4'b0010)) begin
                want = (sel == 4'b0001) ? 7'h08 : 7'h12;
                n_tests++;
                if (seg !== want) begin
                    n_fail++; $display("FAIL b2b_seg sel=%b: got %h required %h", sel, seg, want);
                end
            end
            if (load_ack) begin
                acks++; active = 1;
                if (ack_at < 0) ack_at = i;
            end
        end
        n_tests++;
        if (acks != 1 || ack_at != 0) begin
            n_fail++; $display("FAIL b2b_ack: got count %0d at %0d required 1 at 0", acks, ack_at);
        end
    endtask

    task automatic test_en_low();
        int ack_at;
        advance_to(70);
        disp_data = 16'h9876; load = 1; cyc(); load = 0;
        en = 0; ack_at = -1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_tests++;
            if (obs !== exp_v || sel !== 4'h0) begin
                n_fail++; $display("FAIL en_low_model cyc %0d: got %h required %h", i, obs, exp_v);
            end
            if (load_ack && ack_at < 0) ack_at = i;
        end
        n_tests++;
        if (ack_at < 0 || ack_at > 1) begin
            n_fail++; $display("FAIL en_low_ack: got cycle %0d required 0..1", ack_at);
        end
        en = 1;
        cyc();
        n_tests++;
        if (sel !== 4'b0100 || seg !== 7'h00) begin
            n_fail++; $display("FAIL en_resume: got sel=%b seg=%h required 0100 00", sel, seg);
        end
        for (int i = 0; i < FRAME; i++) begin
            cyc();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL en_resume_model cyc %0d: got %h required %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_rst_mid();
        int acks;
        advance_to(40);
        disp_data = 16'hBEEF; load = 1; cyc(); load = 0;
        rst = 1; cyc();
        n_tests++;
        if (obs !== {7'h7F, 1'b1, 4'h0, 1'b0, 1'b0} || obs !== exp_v) begin
            n_fail++; $display("FAIL rst_mid_idle: got %h required %h", obs, {7'h7F, 1'b1, 4'h0, 1'b0, 1'b0});
        end
        rst = 0; acks = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc();
            n_tests++;
            if (obs !== exp_v || (sel !== 4'h0 && seg !== 7'h40)) begin
                n_fail++; $display("FAIL rst_mid_model cyc %0d: got %h required %h", i, obs, exp_v);
            end
            if (load_ack) acks++;
        end
        n_tests++;
        if (acks != 0) begin
            n_fail++; $display("FAIL rst_mid_ack: got %0d required 0", acks);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 599) == 0);
            en        = ($urandom_range(0, 9) != 0);
            load      = ($urandom_range(0, 49) == 0);
            disp_data = 16'($urandom) >> (4 * $urandom_range(0, 3));
            dp_in     = 4'($urandom);
            blank_in  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 99) == 0) bright = 4'($urandom);
            if ($urandom_range(0, 199) == 0) lzb = ~lzb;
            cyc();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL random_model cyc %0d: got %h required %h", i, obs, exp_v);
            end
        end
        rst = 0; en = 1; load = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_scan();
        test_pwm();
        test_lzb();
        test_back_to_back();
        test_en_low();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
